fifo_rd_streamer: RTL and testbench
===================================

Name: fifo_rd_streamer

Overview:
Read-side drain engine for the dual-clock FIFO. It runs entirely in the read clock domain. It pops words from the FIFO read port in bursts of up to BURST_LEN words and forwards them on a valid/ready output stream through a 2-entry skid buffer. It also keeps a running count of delivered words. It is the consumer the FIFO read port (rinc/rdata/rempty/arempty) was built for.

Parameters:
DATASIZE, 8, FIFO word width in bits
BURST_LEN, 4, maximum words popped per burst (>=1)
CNT_WIDTH, 16, width of delivered-word counter

Ports:
rclk_i  in  1  read-domain clock; all logic on rising edge
rrst_i  in  1  synchronous reset, active-high
en_i  in  1  enables starting new bursts
flush_i  in  1  allows a burst to start while FIFO is almost-empty
fifo_rdata_i  in  DATASIZE  FIFO head word; valid whenever fifo_rempty_i=0 (first-word-fall-through)
fifo_rempty_i  in  1  FIFO empty flag
fifo_arempty_i  in  1  FIFO almost-empty flag
fifo_rinc_o  out  1  pop strobe; FIFO advances on the rising edge where it is 1
m_data_o  out  DATASIZE  output stream data
m_valid_o  out  1  output stream valid
m_ready_i  in  1  output stream ready
rd_cnt_o  out  CNT_WIDTH  total words delivered (valid&&ready handshakes)
busy_o  out  1  1 in READ or HOLD
burst_done_o  out  1  one-cycle pulse on HOLD->IDLE

Behaviour:
- Reset (rrst_i=1 at a rising edge): state=IDLE; skid buffer emptied, contents discarded; beat counter=0; rd_cnt_o=0; m_valid_o=0; m_data_o=0; busy_o=0; burst_done_o=0. fifo_rinc_o is forced 0 combinationally while rrst_i=1.
- Reset mid-burst aborts the burst immediately. Words already popped into the buffer are lost. No pop occurs in the reset cycle.
- Skid buffer: 2 entries, occupancy occ in 0..2. The head entry drives m_data_o. m_valid_o = (occ!=0), registered.
- Handshake: a word transfers on a rising edge with m_valid_o&&m_ready_i. m_data_o and m_valid_o hold stable while m_valid_o=1 and m_ready_i=0.
- Pop condition: fifo_rinc_o = (state==READ) && !fifo_rempty_i && (occ<2 || (occ==2 && m_ready_i)). fifo_rinc_o is combinational from state, occ, fifo_rempty_i and m_ready_i.
- A popped word is captured from fifo_rdata_i on the same edge and appears on m_data_o the next cycle when the buffer was empty. Latency from pop edge to m_valid_o=1 is 1 cycle.
- Simultaneous pop and handshake: occ is unchanged and ordering is preserved (FIFO order strictly kept).
- FSM:
  - IDLE: go to READ when en_i && !fifo_rempty_i && (!fifo_arempty_i || flush_i). Beat counter cleared.
  - READ: each pop increments the beat counter. Go to HOLD on the pop that makes beat==BURST_LEN, or when en_i=0 (pop still allowed that cycle).
  - READ with fifo_rempty_i=1: stay in READ with no pop. Bursts wait; they do not terminate on empty.
  - HOLD: no pops. Go to IDLE when occ==0 and no pending handshake. burst_done_o=1 for the one cycle after entering IDLE from HOLD.
- rd_cnt_o increments by 1 per handshake and wraps modulo 2^CNT_WIDTH (0xFFFF+1 -> 0).
- busy_o = (state!=IDLE).
- A burst never pops more than BURST_LEN words. Buffer overflow is impossible by the pop condition; the verifier asserts occ<=2 and no pop while fifo_rempty_i=1.

Test Plan:
1. FIFO preloaded with 5 words 10,11,12,13,14 (arempty=0), en_i=1, m_ready_i=1 -> first burst pops exactly 4 words on 4 consecutive cycles. m_valid_o rises 1 cycle after the first pop. Stream order is 10..13. burst_done_o pulses once, then a second burst delivers 14. rd_cnt_o=5.
2. 4 words queued, m_ready_i held 0 -> exactly 2 pops occur and fifo_rinc_o stays 0 afterwards. m_data_o is stable at the first word. Raising m_ready_i then delivers all 4 in order with no loss or duplication.
3. FIFO holding 1 word with arempty=1 and flush_i=0 -> no pop and busy_o=0. Setting flush_i=1 -> 1 pop, then READ waits on empty. en_i=0 -> HOLD -> IDLE with burst_done_o pulse.
4. rrst_i asserted one cycle mid-burst with occ=2 -> the next cycle shows m_valid_o=0, rd_cnt_o=0, busy_o=0, and no fifo_rinc_o during reset. The following burst restarts cleanly from the FIFO head.
5. rd_cnt_o preset by delivering 65535 words (CNT_WIDTH=16), then one more handshake -> rd_cnt_o=0.
6. Random m_ready_i and random fifo_rempty_i gaps over 1000 words against a reference queue -> output sequence is identical. No pop occurs while fifo_rempty_i=1 and no burst exceeds BURST_LEN pops.

Source files
------------

// File: rtl/fifo_rd_streamer_if.sv
// rtl/fifo_rd_streamer_if.sv - FIFO read port and output stream bundle for fifo_rd_streamer
interface fifo_rd_streamer_if #(
  parameter int DATASIZE = 8
) ();
  // FIFO read port (first-word-fall-through)
  logic [DATASIZE-1:0] fifo_rdata;
  logic                fifo_rempty;
  logic                fifo_arempty;
  logic                fifo_rinc;
  // valid/ready output stream
  logic [DATASIZE-1:0] m_data;
  logic                m_valid;
  logic                m_ready;

  // streamer side
  modport master (
    input  fifo_rdata, fifo_rempty, fifo_arempty, m_ready,
    output fifo_rinc, m_data, m_valid
  );

  // FIFO / downstream side
  modport slave (
    output fifo_rdata, fifo_rempty, fifo_arempty, m_ready,
    input  fifo_rinc, m_data, m_valid
  );
endinterface

// File: rtl/fifo_rd_streamer.sv
// rtl/fifo_rd_streamer.sv - read-domain burst drain engine with 2-entry skid buffer
module fifo_rd_streamer #(
  parameter int DATASIZE  = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  rclk_i,
  input  logic                  rrst_i,
  input  logic                  en_i,
  input  logic                  flush_i,
  fifo_rd_streamer_if.master    bus_io,
  output logic [CNT_WIDTH-1:0]  rd_cnt_o,
  output logic                  busy_o,
  output logic                  burst_done_o
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_HOLD
  } state_t;

  state_t                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATASIZE-1:0]   head_q, head_d;
  logic [DATASIZE-1:0]   tail_q, tail_d;
  logic                  valid_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  done_q, done_d;
  logic                  pop;
  logic                  hs;

  // A full buffer may still accept a word when the head leaves on the same edge.
  // Reset gates the pop so the FIFO never advances while the burst is being aborted.
  assign pop = !rrst_i && (state_q == S_READ) && !bus_io.fifo_rempty &&
               ((occ_q != 2'd2) || bus_io.m_ready);
  assign hs  = valid_q && bus_io.m_ready;

  assign bus_io.fifo_rinc = pop;
  assign bus_io.m_data    = head_q;
  assign bus_io.m_valid   = valid_q;
  assign rd_cnt_o         = cnt_q;
  assign busy_o           = (state_q != S_IDLE);
  assign burst_done_o     = done_q;

  // Skid buffer next state: head drives the stream, tail holds the second word.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({pop, hs})
      2'b10: begin
        if (occ_q == 2'd0) head_d = bus_io.fifo_rdata;
        else               tail_d = bus_io.fifo_rdata;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = bus_io.fifo_rdata;
        end else begin
          head_d = tail_q;
          tail_d = bus_io.fifo_rdata;
        end
      end
      default: ;
    endcase
  end

  // Burst sequencing: start, count beats, drain, then report completion.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        beat_d = '0;
        if (en_i && !bus_io.fifo_rempty && (!bus_io.fifo_arempty || flush_i)) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (pop) beat_d = beat_q + BEAT_W'(1);
        if ((pop && (beat_q == BEAT_W'(BURST_LEN - 1))) || !en_i) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if ((occ_q == 2'd0) && !hs) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, buffer and delivered-word counter registers.
  always_ff @(posedge rclk_i) begin
    if (rrst_i) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      occ_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= (occ_d != 2'd0);
      done_q  <= done_d;
      if (hs) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb/tb_fifo_rd_streamer.sv - randomized self-checking bench for fifo_rd_streamer
module tb_fifo_rd_streamer;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          flush;
  logic [CW-1:0] rd_cnt;
  logic          busy;
  logic          done;

  fifo_rd_streamer_if #(.DATASIZE(DW)) bus ();

  fifo_rd_streamer #(
    .DATASIZE (DW),
    .BURST_LEN(BL),
    .CNT_WIDTH(CW)
  ) dut (
    .rclk_i      (clk),
    .rrst_i      (rst),
    .en_i        (en),
    .flush_i     (flush),
    .bus_io      (bus),
    .rd_cnt_o    (rd_cnt),
    .busy_o      (busy),
    .burst_done_o(done)
  );

  always #5 clk = ~clk;

  // reference model: FIFO contents and the word stream expected downstream
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int            inflight;
  int            burst_pops;
  int            n_pops;
  int            n_hs;
  int            n_done;
  logic [CW-1:0] model_cnt;
  int            ae_thr;
  int            gap_pct;
  bit            rdy_rand;

  logic          s_rinc, s_valid, s_ready, s_busy, s_done, s_empty;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_cnt;
  logic          p_valid, p_ready, p_rst;
  logic [DW-1:0] p_data;

  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  // One clock: drive the FIFO model, sample before the edge, score, advance.
  task automatic cyc();
    @(negedge clk);
    bus.fifo_rempty  = (fq.size() == 0) || ((gap_pct != 0) && ($urandom_range(99) < gap_pct));
    bus.fifo_rdata   = (fq.size() != 0) ? fq[0] : '0;
    bus.fifo_arempty = (fq.size() <= ae_thr);
    if (rdy_rand) bus.m_ready = 1'($urandom_range(1));
    #1;
    s_rinc  = bus.fifo_rinc;
    s_valid = bus.m_valid;
    s_ready = bus.m_ready;
    s_data  = bus.m_data;
    s_busy  = busy;
    s_done  = done;
    s_empty = bus.fifo_rempty;
    s_cnt   = rd_cnt;

    check_eq("valid_vs_occupancy", s_valid, inflight != 0);
    if (p_valid && !p_ready && !p_rst) begin
      check_eq("hold_valid", s_valid, 1);
      check_eq("hold_data", s_data, p_data);
    end
    if (s_empty || rst) check_eq("no_pop", s_rinc, 0);
    if (!s_busy) burst_pops = 0;

    if (s_valid && s_ready && !rst) begin
      n_hs++;
      check_eq("rd_cnt", s_cnt, model_cnt);
      check_eq("word_available", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_eq("stream_data", s_data, exp_q.pop_front());
      inflight--;
      model_cnt++;
    end
    if (s_rinc && !rst) begin
      if (fq.size() != 0) void'(fq.pop_front());
      inflight++;
      n_pops++;
      burst_pops++;
      check_eq("burst_limit", burst_pops <= BL, 1);
      check_eq("occupancy_max", inflight <= 2, 1);
    end
    if (s_done) n_done++;
    if (rst) begin
      for (int j = 0; j < inflight; j++) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      inflight   = 0;
      model_cnt  = '0;
      burst_pops = 0;
    end
    p_valid = s_valid;
    p_ready = s_ready;
    p_data  = s_data;
    p_rst   = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_drained(input string tag, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      cyc();
      k++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic wait_not_busy(input string tag, input int budget);
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (s_busy && k < budget);
    check_eq(tag, s_busy, 0);
  endtask

  initial begin
    int first_pop, vrise, pops_at_done, base, hs_base, pushed, k;
    int pop_idx[$];

    n_checks = 0; n_fail = 0;
    inflight = 0; burst_pops = 0; n_pops = 0; n_hs = 0; n_done = 0;
    model_cnt = '0; ae_thr = 0; gap_pct = 0; rdy_rand = 0;
    p_valid = 0; p_ready = 0; p_rst = 1; p_data = '0;
    rst = 1; en = 0; flush = 0;
    bus.m_ready = 0; bus.fifo_rempty = 1; bus.fifo_arempty = 1; bus.fifo_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    #1;
    check_eq("rst_valid", bus.m_valid, 0);
    check_eq("rst_data", bus.m_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cnt", rd_cnt, 0);
    check_eq("rst_rinc", bus.fifo_rinc, 0);

    // 1: five words, full-rate sink, burst of four then a burst of one
    ae_thr = 0; en = 1; bus.m_ready = 1; n_done = 0;
    for (int i = 0; i < 5; i++) push_word(DW'(10 + i));
    first_pop = -1; vrise = -1; pops_at_done = -1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (s_rinc) begin
        if (first_pop < 0) first_pop = i;
        pop_idx.push_back(i);
      end
      if (s_valid && vrise < 0) vrise = i;
      if (s_done && pops_at_done < 0) pops_at_done = pop_idx.size();
    end
    check_eq("t1_pops_first_burst", pops_at_done, 4);
    check_eq("t1_total_pops", pop_idx.size(), 5);
    if (pop_idx.size() >= 4) check_eq("t1_consecutive", pop_idx[3] - pop_idx[0], 3);
    check_eq("t1_valid_latency", vrise - first_pop, 1);
    check_eq("t1_done_pulses", n_done, 1);
    check_eq("t1_rd_cnt", rd_cnt, 5);
    check_eq("t1_drained", exp_q.size(), 0);
    en = 0;
    wait_not_busy("t1_idle", 20);

    // 2: stalled sink, buffer fills to two, then releases in order
    bus.m_ready = 0;
    for (int i = 0; i < 4; i++) push_word(DW'(8'h20 + i));
    en = 1; base = n_pops;
    repeat (8) cyc();
    check_eq("t2_pops_while_stalled", n_pops - base, 2);
    base = n_pops;
    repeat (6) cyc();
    check_eq("t2_no_more_pops", n_pops - base, 0);
    check_eq("t2_head_stable", s_data, 8'h20);
    bus.m_ready = 1; hs_base = n_hs;
    run_until_drained("t2_drain", 40);
    check_eq("t2_delivered", n_hs - hs_base, 4);
    en = 0;
    wait_not_busy("t2_idle", 20);

    // 3: almost-empty holds off a burst until flush
    ae_thr = 1; flush = 0; en = 1;
    push_word(8'h30);
    base = n_pops;
    repeat (6) cyc();
    check_eq("t3_no_pop_almost_empty", n_pops - base, 0);
    check_eq("t3_idle", s_busy, 0);
    flush = 1;
    repeat (6) cyc();
    check_eq("t3_flush_pop", n_pops - base, 1);
    check_eq("t3_read_waits", s_busy, 1);
    check_eq("t3_delivered", exp_q.size(), 0);
    n_done = 0; en = 0;
    wait_not_busy("t3_idle_after", 10);
    cyc();
    check_eq("t3_done_pulse", n_done, 1);
    flush = 0;

    // 4: reset with two words buffered
    ae_thr = 0; bus.m_ready = 0; en = 1;
    for (int i = 0; i < 6; i++) push_word(DW'(8'h40 + i));
    k = 0;
    while (inflight != 2 && k < 20) begin
      cyc();
      k++;
    end
    check_eq("t4_occ2", inflight, 2);
    rst = 1; bus.m_ready = 1;
    cyc();
    check_eq("t4_no_pop_in_reset", s_rinc, 0);
    rst = 0;
    cyc();
    check_eq("t4_valid_after_rst", s_valid, 0);
    check_eq("t4_cnt_after_rst", s_cnt, 0);
    check_eq("t4_busy_after_rst", s_busy, 0);
    run_until_drained("t4_restart", 40);
    en = 0;
    wait_not_busy("t4_idle", 20);

    // 5: counter wrap at full scale
    rst = 1;
    cyc();
    rst = 0;
    en = 1; ae_thr = 0; bus.m_ready = 1;
    for (int i = 0; i < (1 << CW) - 1; i++) push_word(DW'($urandom));
    run_until_drained("t5_preset", 2 * (1 << CW) + 200);
    check_eq("t5_cnt_max", rd_cnt, (1 << CW) - 1);
    push_word(8'h5A);
    run_until_drained("t5_last", 20);
    check_eq("t5_wrap", rd_cnt, 0);
    en = 0;
    wait_not_busy("t5_idle", 20);

    // 6: random sink stalls, empty gaps, enable and flush toggling
    ae_thr = 2; gap_pct = 25; rdy_rand = 1; pushed = 0; hs_base = n_hs;
    for (int i = 0; i < 30000 && (pushed < 1000 || exp_q.size() != 0); i++) begin
      if (pushed < 1000 && $urandom_range(3) != 0) begin
        push_word(DW'($urandom));
        pushed++;
      end
      en    = ($urandom_range(9) != 0);
      flush = 1'($urandom_range(1));
      if (pushed == 1000) begin
        en    = 1;
        flush = 1;
      end
      cyc();
    end
    check_eq("t6_delivered", n_hs - hs_base, 1000);
    check_eq("t6_drained", exp_q.size(), 0);
    gap_pct = 0; rdy_rand = 0; bus.m_ready = 1; en = 0; flush = 0;
    wait_not_busy("t6_idle", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
